ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
//  Parametrised AHB-Lite multi-master bus arbiter. Sits between N master agents and the shared address/data mux.
//  Takes per-master hbusreq/hlock and returns one-hot hgrant, hmaster and hmastlock.
//  Adds three things over a fixed 4-bit grant scheme: a configurable master count,
//  selectable fixed-priority or round-robin arbitration, and a burst hold with a bounded beat budget.
// PARAMETERS
//  NUM_MASTERS     4    number of masters, 2..16
//  DEFAULT_MASTER  NUM_MASTERS-1   master granted when nobody requests
//  ARB_MODE        0    0 = fixed priority (lowest index wins), 1 = round robin
//  MAX_HOLD        8    max SEQ beats a non-locked burst keeps the grant while others wait; 0 = no burst hold
// PORTS
//  hclk       in   1            bus clock, all logic on rising edge
//  hreset     in   1            synchronous reset, active-high
//  hbusreq    in   NUM_MASTERS  per-master bus request
//  hlock      in   NUM_MASTERS  per-master locked-transfer request
//  hready     in   1            transfer-complete from slave mux; qualifies every handover
//  htrans     in   2            transfer type of current address phase (IDLE/BUSY/NONSEQ/SEQ)
//  hgrant     out  NUM_MASTERS  one-hot grant (registered)
//  hmaster    out  4            index of master owning the address phase (registered)
//  hmastlock  out  1            current address phase is locked (registered)
// BEHAVIOUR
//  Reset (hreset=1 at edge): hgrant = 1<<DEFAULT_MASTER, hmaster = DEFAULT_MASTER, hmastlock = 0,
//   rr_ptr = DEFAULT_MASTER, hold_cnt = 0. A reset mid-burst or mid-lock abandons it with no residue.
//  hgrant is always exactly one-hot after reset. It never becomes zero-hot or multi-hot.
//  Grant update happens only at an edge with hready=1. With hready=0, hgrant/hmaster/hmastlock hold.
//  Next owner is chosen in this priority order:
//   1. Lock: if hlock[g] & hbusreq[g] for the current grantee g, keep g. Other requests are ignored and hold_cnt is frozen.
//   2. Burst hold: if htrans==SEQ, MAX_HOLD>0 and hold_cnt<MAX_HOLD, keep g.
//   3. Arbitration: if any hbusreq is set, pick the winner.
//      Fixed mode: the lowest set index wins.
//      RR mode: search from rr_ptr+1 upward, wrapping at NUM_MASTERS-1 -> 0.
//   4. No request: grant DEFAULT_MASTER.
//  rr_ptr <= new grantee on every ready-qualified grant change. It is unchanged while the grant is kept.
//  hold_cnt: on a ready edge with htrans==SEQ and the same grantee, hold_cnt += 1, saturating at MAX_HOLD.
//   It clears to 0 on a grant change or when htrans is NONSEQ/IDLE. When it reaches MAX_HOLD and another master requests, the burst is broken.
//  Address-phase pipeline: at a ready edge, hmaster <= index(hgrant current value) and hmastlock <= hlock[that index].
//   So hmaster lags hgrant by exactly one ready-qualified cycle, per AHB handover.
//  Grant latency: a request to an idle bus (grantee not requesting, htrans IDLE, hready=1) is granted at the next edge.
//   hmaster follows one ready edge later.
//  Simultaneous events:
//   - Requests arriving in the same cycle are resolved by the mode rule only.
//   - The grantee deasserting hbusreq while others request means handover on that ready edge.
//   - hlock asserted without hbusreq is ignored.
//  DEFAULT_MASTER keeps the grant while idle even if its own hbusreq=0. It is treated as a normal requester otherwise.
//  NUM_MASTERS<16: unused hmaster MSBs are 0. Out-of-range indices are never produced.
// STRUCTURE
//  Shared items go in integration_pkg:
//   - htrans_e enum (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
//   - arb_mode_e (ARB_FIXED, ARB_RR)
//   - function onehot_to_idx(logic [15:0]) -> logic [3:0]
//   - constant MAX_MASTERS = 16
//  Sub-module ahb_arb_picker is a purely combinational rotating-priority picker.
//   Inputs: req vector, start index. Outputs: one-hot winner and valid. ARB_FIXED drives start = 0.
//  The top holds the hgrant/hmaster/hmastlock/rr_ptr/hold_cnt registers and the lock/hold/default selection.
// TESTING
//  SVA bound through request_if covers: $onehot(hgrant) after reset; no hgrant change on an edge with hready=0;
//   hmaster == $past(onehot_to_idx(hgrant)) on ready edges.
//  Directed scenarios (NUM_MASTERS=4, DEFAULT_MASTER=3, MAX_HOLD=4):
//  1. Reset, all hbusreq=0, hready=1 -> hgrant=4'b1000, hmaster=3, hmastlock=0 on every cycle.
//  2. ARB_MODE=0, hbusreq=4'b0110 -> hgrant=4'b0010 next edge, hmaster=1 one edge later; master 2 waits until hbusreq[1] drops.
//  3. ARB_MODE=1, hbusreq=4'b1111 held, htrans=NONSEQ each beat -> grant rotates 0,1,2,3,0 on successive edges.
//  4. Master 0 granted, NONSEQ then 10 SEQ beats, hbusreq[2]=1 throughout -> grant moves to 2 after the 4th SEQ beat, not before.
//  5. Master 1 with hlock[1]=hbusreq[1]=1 for 20 SEQ beats, hbusreq[0]=1 -> grant stays 1, hmastlock=1 throughout; grant goes to 0 the edge after hlock[1] drops.
//  6. hready=0 for 5 cycles while requests change -> outputs frozen; hreset=1 mid-lock -> reset values next edge, hmastlock=0.

Source files
------------

// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared types and helpers for the AHB-Lite bus arbiter slice.
package ahb_bus_arbiter_pkg;

   localparam int MAX_MASTERS = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_e;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_MASTERS; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface ahb_bus_arbiter_if #(
   parameter int NUM_MASTERS = 4
) ();
   import ahb_bus_arbiter_pkg::*;

   logic [NUM_MASTERS-1:0] hbusreq;
   logic [NUM_MASTERS-1:0] hlock;
   logic                   hready;
   htrans_e                htrans;
   logic [NUM_MASTERS-1:0] hgrant;
   logic [3:0]             hmaster;
   logic                   hmastlock;

   modport master (
      output hbusreq, hlock, hready, htrans,
      input  hgrant, hmaster, hmastlock
   );

   modport slave (
      input  hbusreq, hlock, hready, htrans,
      output hgrant, hmaster, hmastlock
   );

endinterface

// File: rtl/ahb_bus_arbiter_picker.sv
// Combinational rotating-priority picker: first set request at or after start, wrapping.
module ahb_bus_arbiter_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [3:0]   start,
   output logic [N-1:0] gnt,
   output logic         vld
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   int          pos;
   logic        found;
   logic [IW-1:0] sel;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      pos   = 0;
      sel   = '0;
      vld   = |req;
      for (int k = 0; k < N; k++) begin
         pos = int'(start) + k;
         if (pos >= N) pos = pos - N;
         sel = IW'(pos);
         if (!found && req[sel]) begin
            gnt[sel] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB-Lite multi-master arbiter: lock, burst hold with beat budget, fixed or round-robin
// arbitration, and a default master; grant and address-phase owner are registered.
module ahb_bus_arbiter
   import ahb_bus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = NUM_MASTERS - 1,
   parameter int ARB_MODE       = 0,
   parameter int MAX_HOLD       = 8
) (
   input logic               hclk,
   input logic               hreset,
   ahb_bus_arbiter_if.slave  bus
);
   localparam logic [NUM_MASTERS-1:0] DEF_GNT =
      {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   logic [3:0]             rr_ptr;
   logic [7:0]             hold_cnt;
   logic [3:0]             g_idx;
   logic [15:0]            req16;
   logic [15:0]            lock16;
   logic [3:0]             start;
   logic [NUM_MASTERS-1:0] pick_gnt;
   logic                   pick_vld;
   logic                   lock_keep;
   logic                   hold_keep;
   logic [NUM_MASTERS-1:0] next_gnt;
   logic                   changed;

   // Widen per-master vectors so a 4-bit index selects without width games.
   assign req16  = 16'(bus.hbusreq);
   assign lock16 = 16'(bus.hlock);
   assign g_idx  = onehot_to_idx(16'(bus.hgrant));

   always_comb begin
      start = 4'd0;
      if (arb_mode_e'(ARB_MODE[0]) == ARB_RR) begin
         start = (rr_ptr == 4'(NUM_MASTERS - 1)) ? 4'd0 : rr_ptr + 4'd1;
      end
   end

   ahb_bus_arbiter_picker #(.N(NUM_MASTERS)) u_picker (
      .req   (bus.hbusreq),
      .start (start),
      .gnt   (pick_gnt),
      .vld   (pick_vld)
   );

   always_comb begin
      lock_keep = lock16[g_idx] & req16[g_idx];
      hold_keep = (bus.htrans == SEQ) && (MAX_HOLD != 0) && (hold_cnt < HOLD_MAX);
      if (lock_keep || hold_keep) next_gnt = bus.hgrant;
      else if (pick_vld)          next_gnt = pick_gnt;
      else                        next_gnt = DEF_GNT;
      changed = (next_gnt != bus.hgrant);
   end

   // Grant stage and address-phase stage both advance only on ready edges.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         bus.hgrant    <= DEF_GNT;
         bus.hmaster   <= 4'(DEFAULT_MASTER);
         bus.hmastlock <= 1'b0;
         rr_ptr        <= 4'(DEFAULT_MASTER);
         hold_cnt      <= '0;
      end else if (bus.hready) begin
         bus.hgrant    <= next_gnt;
         bus.hmaster   <= g_idx;
         bus.hmastlock <= lock16[g_idx];
         if (changed) begin
            rr_ptr   <= onehot_to_idx(16'(next_gnt));
            hold_cnt <= '0;
         end else if (!lock_keep) begin
            if (bus.htrans == SEQ) begin
               if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 8'd1;
            end else if (bus.htrans != BUSY) begin
               hold_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: one fixed-priority and one round-robin instance.
module tb_ahb_bus_arbiter;
   import ahb_bus_arbiter_pkg::*;

   typedef struct {
      string      tag;
      logic [3:0] g;
      logic [3:0] m;
      logic       l;
   } exp_t;

   logic hclk;
   logic rst_f;
   logic rst_r;
   int   n_cmp;
   int   n_err;
   exp_t sb[$];

   ahb_bus_arbiter_if #(.NUM_MASTERS(4)) bf ();
   ahb_bus_arbiter_if #(.NUM_MASTERS(4)) br ();

   ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(3), .ARB_MODE(0), .MAX_HOLD(4)) u_fix (
      .hclk   (hclk),
      .hreset (rst_f),
      .bus    (bf)
   );

   ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(3), .ARB_MODE(1), .MAX_HOLD(4)) u_rr (
      .hclk   (hclk),
      .hreset (rst_r),
      .bus    (br)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   a_onehot_f: assert property (@(posedge hclk) disable iff (rst_f) $onehot(bf.hgrant));
   a_onehot_r: assert property (@(posedge hclk) disable iff (rst_r) $onehot(br.hgrant));

   task automatic step(input bit rr, input logic rst, input logic rdy,
                       input logic [3:0] req, input logic [3:0] lk, input htrans_e tr,
                       input logic [3:0] eg, input logic [3:0] em, input logic el,
                       input string tag);
      exp_t e;
      logic [3:0] gg, gm;
      logic       gl;
      e.tag = tag; e.g = eg; e.m = em; e.l = el;
      sb.push_back(e);
      if (rr) begin
         rst_r = rst; br.hready = rdy; br.hbusreq = req; br.hlock = lk; br.htrans = tr;
      end else begin
         rst_f = rst; bf.hready = rdy; bf.hbusreq = req; bf.hlock = lk; bf.htrans = tr;
      end
      @(posedge hclk);
      #1;
      e  = sb.pop_front();
      gg = rr ? br.hgrant    : bf.hgrant;
      gm = rr ? br.hmaster   : bf.hmaster;
      gl = rr ? br.hmastlock : bf.hmastlock;
      n_cmp++;
      assert (gg === e.g) else begin
         n_err++;
         $error("FAIL %s hgrant got=%b exp=%b", e.tag, gg, e.g);
      end
      n_cmp++;
      assert (gm === e.m) else begin
         n_err++;
         $error("FAIL %s hmaster got=%0d exp=%0d", e.tag, gm, e.m);
      end
      n_cmp++;
      assert (gl === e.l) else begin
         n_err++;
         $error("FAIL %s hmastlock got=%b exp=%b", e.tag, gl, e.l);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_f = 1'b1; rst_r = 1'b1;
      bf.hready = 1'b1; bf.hbusreq = '0; bf.hlock = '0; bf.htrans = IDLE;
      br.hready = 1'b1; br.hbusreq = '0; br.hlock = '0; br.htrans = IDLE;

      // Reset and idle bus: default master owns everything.
      step(0, 1, 1, 4'b0000, 4'b0000, IDLE, 4'b1000, 4'd3, 1'b0, "s1_reset");
      for (int i = 0; i < 3; i++)
         step(0, 0, 1, 4'b0000, 4'b0000, IDLE, 4'b1000, 4'd3, 1'b0, "s1_idle");

      // Fixed priority: lowest index wins, hmaster lags by one ready edge.
      step(0, 0, 1, 4'b0110, 4'b0000, IDLE, 4'b0010, 4'd3, 1'b0, "s2_grant1");
      step(0, 0, 1, 4'b0110, 4'b0000, IDLE, 4'b0010, 4'd1, 1'b0, "s2_hold1a");
      step(0, 0, 1, 4'b0110, 4'b0000, IDLE, 4'b0010, 4'd1, 1'b0, "s2_hold1b");
      step(0, 0, 1, 4'b0100, 4'b0000, IDLE, 4'b0100, 4'd1, 1'b0, "s2_grant2");
      step(0, 0, 1, 4'b0100, 4'b0000, IDLE, 4'b0100, 4'd2, 1'b0, "s2_mst2");

      // Round robin: all request, grant rotates starting after the default master.
      step(1, 1, 1, 4'b0000, 4'b0000, IDLE,   4'b1000, 4'd3, 1'b0, "s3_reset");
      step(1, 0, 1, 4'b1111, 4'b0000, NONSEQ, 4'b0001, 4'd3, 1'b0, "s3_rot0");
      step(1, 0, 1, 4'b1111, 4'b0000, NONSEQ, 4'b0010, 4'd0, 1'b0, "s3_rot1");
      step(1, 0, 1, 4'b1111, 4'b0000, NONSEQ, 4'b0100, 4'd1, 1'b0, "s3_rot2");
      step(1, 0, 1, 4'b1111, 4'b0000, NONSEQ, 4'b1000, 4'd2, 1'b0, "s3_rot3");
      step(1, 0, 1, 4'b1111, 4'b0000, NONSEQ, 4'b0001, 4'd3, 1'b0, "s3_rot0b");

      // Burst hold: master 0 keeps grant for exactly 4 SEQ beats while master 2 waits.
      step(0, 1, 1, 4'b0000, 4'b0000, IDLE,   4'b1000, 4'd3, 1'b0, "s4_reset");
      step(0, 0, 1, 4'b0101, 4'b0000, IDLE,   4'b0001, 4'd3, 1'b0, "s4_grant0");
      step(0, 0, 1, 4'b0101, 4'b0000, NONSEQ, 4'b0001, 4'd0, 1'b0, "s4_nonseq");
      for (int i = 0; i < 4; i++)
         step(0, 0, 1, 4'b0100, 4'b0000, SEQ, 4'b0001, 4'd0, 1'b0, "s4_held");
      step(0, 0, 1, 4'b0100, 4'b0000, SEQ,    4'b0100, 4'd0, 1'b0, "s4_break");
      step(0, 0, 1, 4'b0100, 4'b0000, NONSEQ, 4'b0100, 4'd2, 1'b0, "s4_mst2");

      // Locked burst: master 1 keeps grant past the hold budget until hlock drops.
      step(0, 1, 1, 4'b0000, 4'b0000, IDLE,   4'b1000, 4'd3, 1'b0, "s5_reset");
      step(0, 0, 1, 4'b0010, 4'b0010, IDLE,   4'b0010, 4'd3, 1'b0, "s5_grant1");
      step(0, 0, 1, 4'b0011, 4'b0010, NONSEQ, 4'b0010, 4'd1, 1'b1, "s5_lock");
      for (int i = 0; i < 20; i++)
         step(0, 0, 1, 4'b0011, 4'b0010, SEQ, 4'b0010, 4'd1, 1'b1, "s5_locked");
      step(0, 0, 1, 4'b0011, 4'b0000, NONSEQ, 4'b0001, 4'd1, 1'b0, "s5_unlock");
      step(0, 0, 1, 4'b0011, 4'b0000, NONSEQ, 4'b0001, 4'd0, 1'b0, "s5_mst0");

      // hready low freezes everything regardless of requests.
      for (int i = 0; i < 5; i++)
         step(0, 0, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), NONSEQ,
              4'b0001, 4'd0, 1'b0, "s6_frozen");
      step(0, 0, 1, 4'b0010, 4'b0010, NONSEQ, 4'b0010, 4'd0, 1'b0, "s6_grant1");
      step(0, 0, 1, 4'b0011, 4'b0010, SEQ,    4'b0010, 4'd1, 1'b1, "s6_lock");
      step(0, 0, 1, 4'b0011, 4'b0010, SEQ,    4'b0010, 4'd1, 1'b1, "s6_lock2");
      // Reset mid-lock, even with hready low, leaves no residue.
      step(0, 1, 0, 4'b0011, 4'b0010, SEQ,    4'b1000, 4'd3, 1'b0, "s6_rst_lock");
      step(0, 0, 1, 4'b0000, 4'b0000, IDLE,   4'b1000, 4'd3, 1'b0, "s6_post_rst");
      step(0, 0, 1, 4'b0001, 4'b0000, IDLE,   4'b0001, 4'd3, 1'b0, "s6_idle_req");
      step(0, 0, 1, 4'b0001, 4'b0000, IDLE,   4'b0001, 4'd0, 1'b0, "s6_idle_mst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
